// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Turns a raw, bouncing, active-low push-button into clean single-cycle step
//   events for the LED shifter. The path is: two-flop synchronizer, counter
//   debouncer, press-edge detect, then an optional hold-to-auto-repeat FSM.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive disagreeing samples needed to flip the
//                     stable level (>=1)
//   REPEAT_EN       : 1 = auto-repeat while held, 0 = one pulse per press
//   REPEAT_DELAY    : cycles from the press pulse to the first repeat (>=1)
//   REPEAT_PERIOD   : cycles between later repeat pulses (>=1)
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   btn_n  : raw asynchronous button, 0 = pressed
//   pressed: debounced level, 1 = held (registered)
//   step   : one-cycle active-high step pulse (registered)
//   step_n : registered inverse of step, feeds the shifter's active-low input
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic step,
  output logic step_n
);

  // Counters only ever reach PARAM-1, so $clog2(PARAM) bits suffice (min 1).
  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_DELAY    = 2'd1,
    S_REPEAT   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer + debouncer
  // ---------------------------------------------------------------------------
  logic [1:0]       sync_q;      // [0] = first flop, [1] = second flop
  logic             stable_q, stable_d;   // 1 = released
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             pressed_q;

  // Next stable level is computed combinationally so the press edge, pressed
  // and step all update on the same clock edge as the debounced flip.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync_q[1] != stable_q) begin
      if (deb_cnt_q == DEB_LAST) stable_d  = sync_q[1];
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 2'b11;
      stable_q  <= 1'b1;
      deb_cnt_q <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_n};
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      pressed_q <= ~stable_d;
    end
  end

  logic press_edge, release_edge;
  assign press_edge   =  stable_q & ~stable_d;
  assign release_edge = ~stable_q &  stable_d;

  // ---------------------------------------------------------------------------
  // Repeat FSM with registered step / step_n
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic             step_q, step_n_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RELEASED;
      rep_cnt_q <= '0;
      step_q    <= 1'b0;
      step_n_q  <= 1'b1;
    end else begin
      step_q   <= 1'b0;
      step_n_q <= 1'b1;
      case (state_q)
        S_RELEASED: begin
          if (press_edge) begin
            step_q    <= 1'b1;
            step_n_q  <= 1'b0;
            rep_cnt_q <= '0;
            state_q   <= S_DELAY;
          end
        end
        S_DELAY: begin
          // Release is checked first so it suppresses a repeat due this edge.
          if (release_edge) begin
            rep_cnt_q <= '0;
            state_q   <= S_RELEASED;
          end else if (!REPEAT_EN) begin
            rep_cnt_q <= '0;
          end else if (rep_cnt_q == REP_DLY_LAST) begin
            step_q    <= 1'b1;
            step_n_q  <= 1'b0;
            rep_cnt_q <= '0;
            state_q   <= S_REPEAT;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (release_edge) begin
            rep_cnt_q <= '0;
            state_q   <= S_RELEASED;
          end else if (rep_cnt_q == REP_PER_LAST) begin
            step_q    <= 1'b1;
            step_n_q  <= 1'b0;
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        default: begin
          rep_cnt_q <= '0;
          state_q   <= S_RELEASED;
        end
      endcase
    end
  end

  assign pressed = pressed_q;
  assign step    = step_q;
  assign step_n  = step_n_q;

endmodule
